// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bundle between the fetch sequencer and imem.
// Handshake: imem_req stays high with a stable imem_addr until the cycle imem_ack is high; that edge completes the transfer.
interface pc_fetch_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: issues imem requests,
// selects PC+1 / branch / jump, honours decode stalls and squashes redirected fetches.
module pc_fetch_sequencer #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_branch_taken,
  input  logic [WIDTH-1:0]       i_branch_target,
  input  logic                   i_jump,
  input  logic [WIDTH-1:0]       i_jump_target,
  pc_fetch_sequencer_if.master   imem,
  output logic [WIDTH-1:0]       o_pc,
  output logic [WIDTH-1:0]       o_pc_incr,
  output logic                   o_fetch_valid,
  output logic [WIDTH-1:0]       o_fetch_pc,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_pend;
  logic [WIDTH-1:0] r_pend_tgt;
  logic             r_fetch_valid;
  logic [WIDTH-1:0] r_fetch_pc;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic             w_pend_nxt;
  logic [WIDTH-1:0] w_pend_tgt_nxt;
  logic             w_fetch_valid_nxt;
  logic [WIDTH-1:0] w_fetch_pc_nxt;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_pc_incr;

  // Jump outranks branch when both arrive in the same cycle.
  assign w_redirect = i_jump | i_branch_taken;
  assign w_target   = i_jump ? i_jump_target : i_branch_target;
  assign w_pc_incr  = r_pc + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_BOOT;
      r_pc          <= RESET_PC;
      r_pend        <= 1'b0;
      r_pend_tgt    <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_pc    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_tgt    <= w_pend_tgt_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pend_nxt        = r_pend;
    w_pend_tgt_nxt    = r_pend_tgt;
    w_fetch_valid_nxt = 1'b0;
    w_fetch_pc_nxt    = r_fetch_pc;

    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_FETCH;
      end

      ST_FETCH: begin
        if (imem.imem_ack) begin
          // A redirect seen while the request was in flight invalidates its data.
          if (w_redirect || r_pend) begin
            w_pc_nxt   = w_redirect ? w_target : r_pend_tgt;
            w_pend_nxt = 1'b0;
          end else begin
            w_fetch_valid_nxt = 1'b1;
            w_fetch_pc_nxt    = r_pc;
            w_pc_nxt          = w_pc_incr;
          end
          w_state_nxt = i_stall ? ST_HOLD : ST_FETCH;
        end else if (w_redirect) begin
          // Address must stay stable until ack, so park the redirect.
          w_pend_nxt     = 1'b1;
          w_pend_tgt_nxt = w_target;
        end
      end

      ST_HOLD: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
        end
        if (!i_stall) begin
          w_state_nxt = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign imem.imem_req  = (r_state == ST_FETCH);
  assign imem.imem_addr = r_pc;

  assign o_pc          = r_pc;
  assign o_pc_incr     = w_pc_incr;
  assign o_fetch_valid = r_fetch_valid;
  assign o_fetch_pc    = r_fetch_pc;
  assign o_state       = r_state;

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter register and sequences instruction fetch for the MIPS datapath.
- Drives the instruction-memory request/acknowledge handshake.
- Selects the next PC from three sources: the increment-by-1 result (PC+1), a branch target, or a jump target.
- Applies pipeline stalls and squashes fetches invalidated by a redirect.

Parameters:
WIDTH, 32, PC / address width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  decode stage cannot accept; suppresses new fetch requests
branch_taken  input  1  redirect to branch_target (1-cycle pulse)
branch_target  input  WIDTH  branch destination address
jump  input  1  redirect to jump_target (1-cycle pulse); priority over branch_taken
jump_target  input  WIDTH  jump destination address
imem_ack  input  1  memory completes current request this cycle
imem_req  output  1  fetch request; equals (state==FETCH)
imem_addr  output  WIDTH  address of current request; equals pc
pc  output  WIDTH  current PC register
pc_incr  output  WIDTH  pc+1, combinational, modulo 2^WIDTH
fetch_valid  output  1  registered; high 1 cycle after a delivered (non-squashed) fetch
fetch_pc  output  WIDTH  registered; address of the fetch flagged by fetch_valid

Behaviour:
- Reset: at any rising edge with rst=1:
  - pc=RESET_PC, state=BOOT, fetch_valid=0, fetch_pc=0.
  - Pending-redirect flag and pending target cleared.
  - imem_req=0.
  - Reset mid-request abandons the request; a late imem_ack is ignored.
- States: BOOT, FETCH, HOLD.
  - BOOT: imem_req=0. Next edge -> FETCH unconditionally; stall is not sampled in BOOT.
  - FETCH: imem_req=1, held until imem_ack. A request is never withdrawn; stall does not abort an outstanding request.
  - HOLD: imem_req=0. Next edge -> FETCH when stall=0; otherwise stay in HOLD.
- Redirect: redirect = jump | branch_taken; target = jump ? jump_target : branch_target.
- FETCH, edge with imem_ack=1:
  - Squash condition: redirect this cycle OR pending flag set.
  - If squashed: fetch_valid<=0. pc <= current target if redirect is high, else the pending target. Pending flag cleared.
  - If not squashed: fetch_valid<=1, fetch_pc<=pc, pc<=pc_incr.
  - Next state: HOLD if stall=1, else stay in FETCH (back-to-back requests, 1 fetch/cycle max).
- FETCH, edge with imem_ack=0 and redirect=1: pending flag<=1, pending target<=target. A later redirect overwrites the pending target. pc is unchanged until the ack.
- HOLD, edge with redirect=1: pc<=target immediately; no pending state involved.
- BOOT, edge with redirect=1: the redirect is ignored.
- fetch_valid is 0 on every edge not described above as delivering.
- Latency: request issued in cycle N with ack in cycle N gives fetch_valid high in cycle N+1. Throughput is 1 fetch per cycle with zero-wait memory.
- Arithmetic: pc_incr wraps, e.g. all-ones + 1 = 0. pc wraps silently with no flag.
- Simultaneous jump and branch_taken: jump wins.

Test Plan:
- Reset, then rst=0 with imem_ack tied 1 -> BOOT for 1 cycle. fetch_pc sequence 0,1,2,3 with fetch_valid high each cycle starting 2 cycles after reset release; pc_incr = pc+1.
- imem_ack delayed 3 cycles per request -> imem_req held high throughout, pc stable during the wait. Each fetch_valid pulse lasts 1 cycle; fetch_pc 0,1,2.
- At pc=5 with ack pending, branch_taken=1, branch_target=40 for 1 cycle, ack 2 cycles later -> no fetch_valid for pc 5. pc=40 after the ack; next delivered fetch_pc=40.
- jump=1 (jump_target=100) and branch_taken=1 (branch_target=200) on the same ack edge -> pc=100, fetch squashed.
- stall=1 on the ack edge at pc=7 -> fetch_pc=7 delivered, state HOLD, imem_req=0, pc=8 while stalled. stall=0 -> request for address 8 next cycle.
- RESET_PC=32'hFFFF_FFFF, ack tied 1 -> fetch_pc FFFF_FFFF then 0. rst asserted mid-wait -> imem_req=0 next cycle and the next fetch starts at RESET_PC.
